// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and its clear controller.
package data_memory_pkg;

  // Defaults shared with the instruction memory.
  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_DEPTH  = 256;

  // ST_CLEAR: zeroing sweep in progress. ST_READY: normal service.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_clear_ctrl.sv
// Controller for the post-reset zeroing sweep.
// It owns the state register, the sweep pointer and the busy/access_err flags.
// It exports a write strobe and address that the top muxes onto the array port.
module mem_clear_ctrl
  import data_memory_pkg::*;
#(
  parameter  int DEPTH          = DMEM_DEPTH,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  output logic              o_busy,
  output logic              o_access_err,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_busy;
  logic              r_access_err;

  // State, sweep pointer and status flags. A held reset pins the pointer at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      r_busy       <= CLEAR_ON_RESET;
      r_clr_ptr    <= '0;
      r_access_err <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Requests are dropped during the sweep; flag each one.
          r_access_err <= i_req;
          r_clr_ptr    <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_access_err <= 1'b0;
        end
      endcase
    end
  end

  // The reset cycle must never complete a write or a read, so gate on rst.
  assign o_clr_we     = (r_state == ST_CLEAR) && !rst;
  assign o_ready      = (r_state == ST_READY) && !rst;
  assign o_clr_addr   = r_clr_ptr;
  assign o_busy       = r_busy;
  assign o_access_err = r_access_err;

endmodule

// File: rtl/data_memory_sync.sv
// Single-port data memory with synchronous write and a registered read.
// After reset, an optional hardware sweep zeroes the array while busy is high.
// The array has no reset of its own, so it still maps onto block RAM.
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter  int DATA_W         = DMEM_DATA_W,
  parameter  int DEPTH          = DMEM_DEPTH,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_ram,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memwrite,
  input  logic              memread,
  output logic [DATA_W-1:0] read_ram_data,
  output logic              read_valid,
  output logic              busy,
  output logic              access_err
);

  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rd;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_read_valid;

  mem_clear_ctrl #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk          (clk),
    .rst          (rst),
    .i_req        (memwrite | memread),
    .o_busy       (busy),
    .o_access_err (access_err),
    .o_ready      (w_ready),
    .o_clr_we     (w_clr_we),
    .o_clr_addr   (w_clr_addr)
  );

  // The sweep owns the write port while it runs; otherwise it serves the datapath.
  assign w_we    = w_clr_we | (w_ready & memwrite);
  assign w_waddr = w_clr_we ? w_clr_addr : address_ram;
  assign w_wdata = w_clr_we ? '0 : write_data;
  assign w_rd    = w_ready & memread;

  // Array write port (no reset, keeps RAM inference).
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Registered read with write-first forwarding on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata      <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd;
      if (w_rd) r_rdata <= memwrite ? write_data : r_mem[address_ram];
    end
  end

  assign read_ram_data = r_rdata;
  assign read_valid    = r_read_valid;

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync. Two instances share the stimulus: one clears on
// reset and one retains its contents. Each instance is checked against an
// array-level reference model after every clock edge.
module tb_data_memory_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] address_ram = '0;
  logic [7:0] write_data  = '0;
  logic       memwrite    = 1'b0;
  logic       memread     = 1'b0;

  logic [7:0] rd_a, rd_b;
  logic       vld_a, vld_b, busy_a, busy_b, err_a, err_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [7:0] ma [256];
  logic [7:0] mb [256];
  bit         mbk [256];
  int         a_left = 0;
  logic [7:0] ea_rd = '0, eb_rd = '0;
  bit         eb_rdk = 1'b0;
  bit         ea_vld, ea_busy, ea_err, eb_vld;

  always #5 clk = ~clk;

  data_memory_sync #(.DATA_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst), .address_ram(address_ram), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .read_ram_data(rd_a),
    .read_valid(vld_a), .busy(busy_a), .access_err(err_a)
  );

  data_memory_sync #(.DATA_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst), .address_ram(address_ram), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .read_ram_data(rd_b),
    .read_valid(vld_b), .busy(busy_b), .access_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance models on the edge, then compare.
  task automatic cyc(input bit r, input bit we, input bit re,
                     input logic [7:0] a, input logic [7:0] d);
    rst = r; memwrite = we; memread = re; address_ram = a; write_data = d;
    @(posedge clk);
    // Clearing instance: contents are unreachable until the sweep finishes,
    // so the model zeroes everything at reset.
    if (r) begin
      ea_rd = '0; ea_vld = 0; ea_err = 0; a_left = 256;
      foreach (ma[i]) ma[i] = '0;
    end else if (a_left > 0) begin
      ea_err = we | re; ea_vld = 0; a_left--;
    end else begin
      ea_err = 0;
      if (we) ma[a] = d;
      ea_vld = re;
      if (re) ea_rd = ma[a];
    end
    ea_busy = (a_left > 0);
    // Retaining instance: never busy, memory survives reset.
    if (r) begin
      eb_rd = '0; eb_rdk = 1; eb_vld = 0;
    end else begin
      if (we) begin mb[a] = d; mbk[a] = 1; end
      eb_vld = re;
      if (re) begin eb_rd = mb[a]; eb_rdk = mbk[a]; end
    end
    #1;
    chk("a_busy", 32'(busy_a), 32'(ea_busy));
    chk("a_err",  32'(err_a),  32'(ea_err));
    chk("a_vld",  32'(vld_a),  32'(ea_vld));
    chk("a_rd",   32'(rd_a),   32'(ea_rd));
    chk("b_busy", 32'(busy_b), 32'd0);
    chk("b_err",  32'(err_b),  32'd0);
    chk("b_vld",  32'(vld_b),  32'(eb_vld));
    if (eb_rdk) chk("b_rd", 32'(rd_b), 32'(eb_rd));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    int n;
    // Reset for two cycles.
    cyc(1, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00);
    chk("rst_rd_a", 32'(rd_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd1);

    // Sweep length, with a write dropped at sweep cycle 10.
    n = 0;
    for (int i = 0; i < 300 && busy_a; i++) begin
      n++;
      if (i == 10) cyc(0, 1, 0, 8'h05, 8'h55);
      else idle();
    end
    chk("busy_len", 32'(n), 32'd256);

    // Cleared words read back as zero.
    cyc(0, 0, 1, 8'h00, 8'h00); chk("clr_00", 32'(rd_a), 32'h00);
    cyc(0, 0, 1, 8'h7F, 8'h00); chk("clr_7f", 32'(rd_a), 32'h00);
    cyc(0, 0, 1, 8'hFF, 8'h00); chk("clr_ff", 32'(rd_a), 32'h00);
    cyc(0, 0, 1, 8'h05, 8'h00); chk("drop_05", 32'(rd_a), 32'h00);
    idle();

    // Write then read, then hold.
    cyc(0, 1, 0, 8'h10, 8'hA5);
    cyc(0, 0, 1, 8'h10, 8'h00);
    chk("wr_rd_10", 32'(rd_a), 32'hA5);
    chk("wr_vld", 32'(vld_a), 32'd1);
    idle();
    chk("hold_rd", 32'(rd_a), 32'hA5);
    chk("hold_vld", 32'(vld_a), 32'd0);

    // Simultaneous write and read: write-first.
    cyc(0, 1, 1, 8'h20, 8'h3C);
    chk("wf_rd", 32'(rd_a), 32'h3C);
    idle();
    cyc(0, 0, 1, 8'h20, 8'h00);
    chk("wf_later", 32'(rd_a), 32'h3C);

    // Reset mid-stream: the clearing instance loses 0x77, the other keeps it.
    cyc(0, 1, 0, 8'h40, 8'h77);
    cyc(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) idle();
    cyc(0, 0, 1, 8'h40, 8'h00);
    chk("rst_a_40", 32'(rd_a), 32'h00);
    chk("rst_b_40", 32'(rd_b), 32'h77);

    // Back-to-back reads over a preloaded block.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'(i), 8'(i) ^ 8'hFF);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 8'(i), 8'h00);
      chk("seq_rd", 32'(rd_a), 32'(8'hFF - 8'(i)));
      chk("seq_vld", 32'(vld_a), 32'd1);
    end
    idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 299) == 0, 1'($urandom), 1'($urandom),
          8'($urandom_range(0, 31)), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
Parametrised, clocked successor to the 8-bit data RAM. It is a single-port data memory with synchronous write and registered read. On reset it clears the whole array with a hardware sweep, and a busy flag is high while the sweep runs. It sits between the datapath's load/store stage and the control unit, which must honour busy and read_valid.

Parameters:
- DATA_W, 8, width of each memory word and of the data buses.
- DEPTH, 256, number of words. Must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width. Localparam, derived, not overridable.
- CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = reset affects only the control/output registers and memory contents are retained.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- address_ram  input  ADDR_W  word address for read or write.
- write_data  input  DATA_W  data to store.
- memwrite  input  1  write request, sampled each clk edge.
- memread  input  1  read request, sampled each clk edge.
- read_ram_data  output  DATA_W  registered read data; holds its value between reads.
- read_valid  output  1  one-cycle pulse: read_ram_data was updated this cycle.
- busy  output  1  clear sweep in progress; requests are not serviced.
- access_err  output  1  one-cycle pulse: a request arrived while busy and was dropped.

Behaviour:
- Reset, when rst is high at a clk edge:
  - read_ram_data=0, read_valid=0, access_err=0, clr_ptr=0.
  - state=CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state=READY and busy=0.
  - rst held high keeps clr_ptr at 0, so the sweep restarts. Reset asserted mid-sweep or mid-operation restarts from this state. No partial write completes in a reset cycle.
- State machine, two states:
  - CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr+1. When clr_ptr==DEPTH-1, the last word is written and the next state is READY.
  - Result: busy is high for exactly DEPTH cycles after the first cycle with rst low. busy is a registered output: 1 in CLEAR, 0 in READY.
  - READY: normal service; stays here until rst.
- Write (READY, memwrite=1): mem[address_ram] <= write_data at the edge. Visible to a read issued the next cycle.
- Read (READY, memread=1): read_ram_data <= mem[address_ram] at the edge. read_valid=1 in the following cycle only, so latency is 1 clk.
  - Back-to-back reads give read_valid high continuously.
  - With no read, read_ram_data holds its value and read_valid=0.
- Simultaneous memwrite and memread:
  - Same address: write-first; read_ram_data = write_data and the array is updated.
  - Different addresses are not possible on a single port; the address applies to both requests, so this is the same-address case.
- Requests during busy: no array write and no read update. access_err=1 for the cycle after each edge that saw memwrite or memread high while in CLEAR. The sweep is unaffected.
- Address wrap: ADDR_W exactly spans DEPTH, so every address is legal and there is no out-of-range case.
- The array itself has no per-word reset. Zeroing happens only through the sweep, which keeps it inferable as block RAM.

Decomposition:
- Shared package data_memory_pkg:
  - state enum: ST_CLEAR, ST_READY.
  - default DATA_W/DEPTH constants shared with the instruction memory.
- Natural sub-module: mem_clear_ctrl, holding the state register, clr_ptr counter, busy and access_err. It exports clr_we/clr_addr, which are muxed onto the array write port inside data_memory_sync.

Test Plan:
1. DEPTH=256, CLEAR_ON_RESET=1; rst high 2 cycles then low → busy=1 for exactly 256 cycles then 0. Afterwards, reads of addresses 0x00, 0x7F and 0xFF each return 0x00 with read_valid pulsing one cycle after each request.
2. Write 0xA5 @0x10, next cycle read @0x10 → read_ram_data=0xA5 and read_valid=1 one cycle later. With no further read, the value stays 0xA5 and read_valid=0.
3. memwrite=memread=1, addr 0x20, data 0x3C in one cycle → read_ram_data=0x3C the next cycle; a later read @0x20 also returns 0x3C.
4. During the sweep, issue write 0x55 @0x05 at sweep cycle 10 → access_err pulses once. After busy falls, a read @0x05 returns 0x00.
5. Write 0x77 @0x40, assert rst for 1 cycle mid-stream, then re-clear → read @0x40 returns 0x00. With CLEAR_ON_RESET=0 the same sequence returns 0x77 and busy never rises.
6. Reads every cycle at addresses 0..15, each preloaded with addr^0xFF → 16 consecutive read_valid cycles with data 0xFF, 0xFE, … 0xF0 in order.
